// File: rtl/z80_bus_pkg.sv
// rtl/z80_bus_pkg.sv - shared cycle/state types and constants for the z80 bus responder
package z80_bus_pkg;

   typedef enum logic [2:0] {
      CYC_NONE,
      CYC_MEM_RD,
      CYC_MEM_WR,
      CYC_IO_RD,
      CYC_IO_WR,
      CYC_INTACK
   } cyc_e;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DONE
   } state_e;

   localparam logic [7:0] Z80_BUS_IDLE_DATA = 8'hFF;

endpackage

// File: rtl/z80_cycle_decode.sv
// rtl/z80_cycle_decode.sv - combinational Z80 strobe decode; INTACK decoded only with Z80_BUS_INTACK_EN
module z80_cycle_decode
   import z80_bus_pkg::*;
(
   input  logic m1_n_i,
   input  logic mreq_n_i,
   input  logic iorq_n_i,
   input  logic rd_n_i,
   input  logic wr_n_i,
   input  logic rfsh_n_i,
   output cyc_e cyc_o
);

   always_comb begin
      cyc_o = CYC_NONE;
      if (!mreq_n_i && rfsh_n_i) begin
         if (!rd_n_i) begin
            cyc_o = CYC_MEM_RD;
         end else if (!wr_n_i) begin
            cyc_o = CYC_MEM_WR;
         end
      end else if (!iorq_n_i && mreq_n_i) begin
         if (m1_n_i) begin
            if (!rd_n_i) begin
               cyc_o = CYC_IO_RD;
            end else if (!wr_n_i) begin
               cyc_o = CYC_IO_WR;
            end
         end
`ifdef Z80_BUS_INTACK_EN
         else begin
            cyc_o = CYC_INTACK;
         end
`endif
      end
   end

endmodule

// File: rtl/z80_bus_responder.sv
// rtl/z80_bus_responder.sv - Z80 bus slave to valid/ack backend bridge; Z80_BUS_INTACK_EN enables local INTACK response
module z80_bus_responder
   import z80_bus_pkg::*;
#(
   parameter int         TIMEOUT    = 64,
   parameter logic [7:0] INT_VECTOR = 8'hFF
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] cpu_a,
   input  logic [7:0]  cpu_do,
   output logic [7:0]  cpu_di,
   input  logic        m1_n,
   input  logic        mreq_n,
   input  logic        iorq_n,
   input  logic        rd_n,
   input  logic        wr_n,
   input  logic        rfsh_n,
   output logic        wait_n,
   output logic        bk_req,
   output logic        bk_we,
   output logic        bk_io,
   output logic [15:0] bk_addr,
   output logic [7:0]  bk_wdata,
   input  logic [7:0]  bk_rdata,
   input  logic        bk_ack,
   output logic        timeout_err
);

`ifdef Z80_BUS_INTACK_EN
   localparam bit INTACK_EN = 1'b1;
`else
   localparam bit INTACK_EN = 1'b0;
`endif

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

   cyc_e        cyc;
   state_e      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        bk_req_q, bk_req_d;
   logic        wait_n_q, wait_n_d;
   logic [7:0]  cpu_di_q, cpu_di_d;
   logic        bk_we_q, bk_we_d;
   logic        bk_io_q, bk_io_d;
   logic [15:0] bk_addr_q, bk_addr_d;
   logic [7:0]  bk_wdata_q, bk_wdata_d;
   logic        terr_q, terr_d;
   logic        intack_q, intack_d;
   logic        strobes_idle;
   logic        finish;

   z80_cycle_decode u_decode (
      .m1_n_i   (m1_n),
      .mreq_n_i (mreq_n),
      .iorq_n_i (iorq_n),
      .rd_n_i   (rd_n),
      .wr_n_i   (wr_n),
      .rfsh_n_i (rfsh_n),
      .cyc_o    (cyc)
   );

   assign strobes_idle = mreq_n && iorq_n;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         cnt_q      <= 8'd0;
         bk_req_q   <= 1'b0;
         wait_n_q   <= 1'b1;
         cpu_di_q   <= Z80_BUS_IDLE_DATA;
         bk_we_q    <= 1'b0;
         bk_io_q    <= 1'b0;
         bk_addr_q  <= 16'd0;
         bk_wdata_q <= 8'd0;
         terr_q     <= 1'b0;
         intack_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bk_req_q   <= bk_req_d;
         wait_n_q   <= wait_n_d;
         cpu_di_q   <= cpu_di_d;
         bk_we_q    <= bk_we_d;
         bk_io_q    <= bk_io_d;
         bk_addr_q  <= bk_addr_d;
         bk_wdata_q <= bk_wdata_d;
         terr_q     <= terr_d;
         intack_q   <= intack_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bk_req_d   = bk_req_q;
      wait_n_d   = wait_n_q;
      cpu_di_d   = cpu_di_q;
      bk_we_d    = bk_we_q;
      bk_io_d    = bk_io_q;
      bk_addr_d  = bk_addr_q;
      bk_wdata_d = bk_wdata_q;
      terr_d     = terr_q;
      intack_d   = intack_q;
      finish     = 1'b0;
      case (state_q)
         IDLE: begin
            if (cyc != CYC_NONE) begin
               state_d    = ISSUE;
               cnt_d      = 8'd0;
               wait_n_d   = 1'b0;
               bk_addr_d  = cpu_a;
               bk_wdata_d = cpu_do;
               bk_we_d    = (cyc == CYC_MEM_WR) || (cyc == CYC_IO_WR);
               bk_io_d    = (cyc == CYC_IO_RD) || (cyc == CYC_IO_WR);
               intack_d   = INTACK_EN && (cyc == CYC_INTACK);
               bk_req_d   = !(INTACK_EN && (cyc == CYC_INTACK));
            end
         end
         ISSUE: begin
            cnt_d = cnt_q + 8'd1;
            // ack beats a timeout landing on the same edge
            if (intack_q) begin
               cpu_di_d = INT_VECTOR;
               finish   = 1'b1;
            end else if (bk_ack) begin
               if (!bk_we_q) begin
                  cpu_di_d = bk_rdata;
               end
               finish = 1'b1;
            end else if (cnt_q == TIMEOUT_LAST) begin
               cpu_di_d = Z80_BUS_IDLE_DATA;
               terr_d   = 1'b1;
               finish   = 1'b1;
            end
            if (finish) begin
               bk_req_d = 1'b0;
               wait_n_d = 1'b1;
               intack_d = 1'b0;
               state_d  = strobes_idle ? IDLE : DONE;
            end
         end
         DONE: begin
            if (strobes_idle) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign cpu_di      = cpu_di_q;
   assign wait_n      = wait_n_q;
   assign bk_req      = bk_req_q;
   assign bk_we       = bk_we_q;
   assign bk_io       = bk_io_q;
   assign bk_addr     = bk_addr_q;
   assign bk_wdata    = bk_wdata_q;
   assign timeout_err = terr_q;

endmodule

// File: tb/tb_z80_bus_responder.sv
// tb/tb_z80_bus_responder.sv - self-checking bench for z80_bus_responder (optionally built with Z80_BUS_INTACK_EN)
module tb_z80_bus_responder;

   localparam int         TO = 8;
   localparam logic [7:0] IV = 8'h38;
   localparam int T_MRD = 0, T_MWR = 1, T_IRD = 2, T_IWR = 3, T_RFSH = 4, T_INTA = 5;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic [15:0] cpu_a = 16'd0;
   logic [7:0]  cpu_do = 8'd0;
   logic [7:0]  cpu_di;
   logic        m1_n = 1'b1, mreq_n = 1'b1, iorq_n = 1'b1;
   logic        rd_n = 1'b1, wr_n = 1'b1, rfsh_n = 1'b1;
   logic        wait_n, bk_req, bk_we, bk_io, timeout_err;
   logic [15:0] bk_addr;
   logic [7:0]  bk_wdata;
   logic [7:0]  bk_rdata = 8'd0;
   logic        bk_ack = 1'b0;

   always #5 clk = ~clk;

   z80_bus_responder #(.TIMEOUT(TO), .INT_VECTOR(IV)) dut (
      .clk(clk), .reset_n(reset_n), .cpu_a(cpu_a), .cpu_do(cpu_do), .cpu_di(cpu_di),
      .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n),
      .wait_n(wait_n), .bk_req(bk_req), .bk_we(bk_we), .bk_io(bk_io), .bk_addr(bk_addr),
      .bk_wdata(bk_wdata), .bk_rdata(bk_rdata), .bk_ack(bk_ack), .timeout_err(timeout_err)
   );

   typedef struct {
      int          typ;
      logic [15:0] addr;
      logic [7:0]  wdata;
      int          delay;   // 0 = backend never acks
      logic [7:0]  rdata;
      bit          early;   // CPU drops strobes right after detection
      bit          late;    // stray ack pulse after completion
   } vec_t;

   int         n_vec = 0;
   int         n_bad = 0;
   logic [7:0] exp_di = 8'hFF;
   logic       exp_terr = 1'b0;
   vec_t       vecs[8];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic release_strobes();
      m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; rfsh_n = 1'b1;
   endtask

   task automatic set_strobes(input int typ);
      release_strobes();
      case (typ)
         T_MRD:  begin mreq_n = 1'b0; rd_n = 1'b0; m1_n = $urandom_range(0, 1) == 0; end
         T_MWR:  begin mreq_n = 1'b0; wr_n = 1'b0; end
         T_IRD:  begin iorq_n = 1'b0; rd_n = 1'b0; end
         T_IWR:  begin iorq_n = 1'b0; wr_n = 1'b0; end
         T_RFSH: begin mreq_n = 1'b0; rfsh_n = 1'b0; end
         default: begin iorq_n = 1'b0; m1_n = 1'b0; end
      endcase
   endtask

   task automatic run_cycle(input vec_t v);
      int low = 0, reqs = 0, reqcyc = 0, exp_low, exp_reqs;
      bit saw_low = 0, prev_req = 0, fld_bad = 0;
      bit is_wr, is_io, data_cyc, acked;
      is_wr    = (v.typ == T_MWR) || (v.typ == T_IWR);
      is_io    = (v.typ == T_IRD) || (v.typ == T_IWR);
      data_cyc = v.typ <= T_IWR;
      acked    = (v.delay != 0) && (v.delay <= TO);
      exp_reqs = data_cyc ? 1 : 0;
      exp_low  = data_cyc ? (acked ? v.delay : TO) : 0;
`ifdef Z80_BUS_INTACK_EN
      if (v.typ == T_INTA) exp_low = 1;
`endif
      @(negedge clk);
      cpu_a = v.addr; cpu_do = v.wdata; bk_rdata = v.rdata;
      set_strobes(v.typ);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bk_req) begin
            reqcyc++;
            if (!prev_req) reqs++;
            if (bk_addr !== v.addr || bk_wdata !== v.wdata || bk_we !== is_wr || bk_io !== is_io)
               fld_bad = 1;
         end
         prev_req = bk_req;
         if (!wait_n) begin low++; saw_low = 1; end
         if ((saw_low && wait_n) || (!saw_low && i >= 5)) break;
         bk_ack = bk_req && (reqcyc == v.delay);
         if (v.early && i == 0) release_strobes();
      end
      bk_ack = 1'b0;
      if (v.late) begin
         bk_ack = 1'b1;
         @(negedge clk);
         bk_ack = 1'b0;
      end
      release_strobes();
      repeat (2) @(negedge clk);
      if (data_cyc) begin
         if (acked) begin
            if (!is_wr) exp_di = v.rdata;
         end else begin
            exp_di   = 8'hFF;
            exp_terr = 1'b1;
         end
      end
`ifdef Z80_BUS_INTACK_EN
      if (v.typ == T_INTA) exp_di = IV;
`endif
      check("wait_low_cycles", low, exp_low);
      check("bk_req_count", reqs, exp_reqs);
      if (exp_reqs != 0) check("latched_fields_bad", fld_bad, 0);
      check("cpu_di", cpu_di, exp_di);
      check("timeout_err", timeout_err, exp_terr);
      check("idle_req_wait", {bk_req, wait_n}, 2'b01);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{T_MRD,  16'h1234, 8'h00, 3, 8'hA5, 0, 0};
      vecs[1] = '{T_MWR,  16'h8000, 8'h3C, 1, 8'h00, 0, 0};
      vecs[2] = '{T_IWR,  16'h007F, 8'h5A, 2, 8'h00, 0, 0};
      vecs[3] = '{T_RFSH, 16'h0040, 8'h00, 1, 8'h00, 0, 0};
      vecs[4] = '{T_MRD,  16'h2222, 8'h11, 0, 8'h99, 0, 1};
      vecs[5] = '{T_MRD,  16'h3333, 8'h22, TO, 8'h77, 0, 0};
      vecs[6] = '{T_IRD,  16'h0011, 8'h33, 1, 8'hC3, 1, 0};
      vecs[7] = '{T_INTA, 16'h0000, 8'h00, 1, 8'h5E, 0, 0};

      #1 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_cpu_di", cpu_di, 8'hFF);
      check("rst_wait_req", {wait_n, bk_req, bk_we, bk_io}, 4'b1000);
      check("rst_addr_wdata", {bk_addr, bk_wdata}, 24'd0);
      check("rst_timeout_err", timeout_err, 1'b0);
      reset_n = 1'b1;

      for (int i = 0; i < 8; i++) run_cycle(vecs[i]);

      // reset while a request is outstanding
      @(negedge clk);
      cpu_a = 16'h4242; set_strobes(T_MRD);
      repeat (3) @(negedge clk);
      check("midreset_req_pending", bk_req, 1'b1);
      reset_n = 1'b0;
      #1;
      check("midreset_req", bk_req, 1'b0);
      check("midreset_wait", wait_n, 1'b1);
      check("midreset_cpu_di", cpu_di, 8'hFF);
      check("midreset_terr", timeout_err, 1'b0);
      exp_di = 8'hFF; exp_terr = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      release_strobes();
      run_cycle('{T_MRD, 16'h4242, 8'h44, 2, 8'h6B, 0, 0});

      for (int i = 0; i < 40; i++) begin
         vec_t r;
         r.typ   = $urandom_range(0, 5);
         r.addr  = 16'($urandom);
         r.wdata = 8'($urandom);
         r.delay = $urandom_range(0, 3) == 0 ? $urandom_range(0, TO + 2) : $urandom_range(1, 4);
         r.rdata = 8'($urandom);
         r.early = $urandom_range(0, 3) == 0;
         r.late  = 0;
         run_cycle(r);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
